pe_traffic_node: RTL and testbench
==================================

// Module: pe_traffic_node
// PURPOSE
//   Processing-element endpoint attached to one HNoC local port (i_pe_dataN / o_pe_dataN).
//   Injects pseudo-random-destination flits into the NoC at a fixed rate and sinks flits the
//   NoC delivers to it. Keeps TX/RX counts for throughput and latency studies in the 16-node bench.
//   Flit format (32b): [31:28] dest addr, [27:24] src addr, [23:0] sequence number.
// PARAMETERS
//   ADDRESS     0        own node address, 0..NUM_NODES-1
//   ADDR_W      4        address field width; NUM_NODES = 2**ADDR_W
//   DATA_W      32       flit width (fixed layout above; ADDR_W=4 only)
//   INJ_PERIOD  8        cycles from one accepted flit to next o_data_valid rise, >=1
//   NUM_PKTS    100      flits to inject before DONE; 0 = unlimited
//   LFSR_SEED   16'hACE1 LFSR seed, XORed with ADDRESS; never zero
// PORTS
//   clk           in   1       clock
//   rst           in   1       asynchronous reset, active-high
//   i_enable      in   1       injection enable
//   i_data        in   DATA_W  flit from NoC
//   i_data_valid  in   1       flit from NoC valid
//   o_data_ready  out  1       node can accept flit
//   o_data        out  DATA_W  flit to NoC
//   o_data_valid  out  1       flit to NoC valid
//   i_data_ready  in   1       NoC can accept flit
//   o_tx_count    out  32      flits accepted by NoC
//   o_rx_count    out  32      flits received
//   o_done        out  1       NUM_PKTS flits sent
//   o_err_count   out  16      RX check failures (0 without RX_CHECK_EN)
// BEHAVIOUR
//   Reset: all outputs 0; FSM=IDLE; seq=0; LFSR=LFSR_SEED^ADDRESS. o_data_ready=1 from first
//   clk edge after rst deasserts (sink never stalls). Reset mid-packet drops the flit silently.
//   FSM: IDLE -(i_enable)-> GAP or SEND; GAP -(gap count expired)-> SEND;
//   SEND -(valid&ready, more to send)-> GAP (SEND if INJ_PERIOD=1); SEND -(last flit)-> DONE;
//   GAP -(!i_enable)-> IDLE; SEND ignores i_enable until handshake, then -> IDLE if low; DONE sticky.
//   Leaving IDLE: o_data_valid rises INJ_PERIOD cycles after the i_enable-sampling edge.
//   Handshake: transfer on o_data_valid&&i_data_ready at posedge; o_data and o_data_valid held
//   stable while valid&&!ready; valid never withdrawn before transfer.
//   Rate: with i_data_ready=1, valid low exactly INJ_PERIOD-1 cycles between flits; period 1 =
//   back-to-back. Stall cycles do not shorten the following gap.
//   Dest: 16b Galois LFSR (taps x^16+x^14+x^13+x^11+1) advances once per transfer;
//   dest=lfsr[3:0]; if dest==ADDRESS use dest+1 mod 16. Flit never self-addressed.
//   seq increments per transfer, wraps 2^24-1 -> 0. o_tx_count/o_rx_count wrap at 2^32.
//   o_rx_count += 1 on each cycle i_data_valid&&o_data_ready; same-cycle TX and RX independent.
//   o_done=1 the cycle after the NUM_PKTS-th transfer; never set if NUM_PKTS=0.
// CONFIGURATION
//   RX_CHECK_EN defined: each received flit checked: dest field==ADDRESS, and seq == expected
//   seq for its src (16-entry table, init 0, set to seq+1 on every flit). Each failing flit adds 1
//   to o_err_count (saturates 16'hFFFF); both failures in one flit count once.
//   RX_CHECK_EN undefined: no table/checker logic, o_err_count tied to 0.
// STRUCTURE
//   noc_pkg: ADDR_W, NUM_NODES, flit field offsets (DEST_MSB/LSB, SRC_*, SEQ_*), LFSR taps,
//   FSM state encodings, make_flit(dest,src,seq) function.
//   Sub-module traffic_rx_checker (expected-seq table + compare), instantiated only under RX_CHECK_EN.
// TESTING
//   1 ADDRESS=3, INJ_PERIOD=4, NUM_PKTS=5, ready=1 -> 5 flits, valid high 1 cycle every 4,
//     src=3, seq 0..4, no dest==3, o_done=1 cycle after 5th, o_tx_count=5.
//   2 INJ_PERIOD=1, ready low cycles 2-6 of a packet -> o_data/valid stable while stalled,
//     no duplicate/lost seq, next flit valid the cycle after transfer.
//   3 drop i_enable in GAP then SEND -> GAP: IDLE next cycle; SEND: flit held until ready then
//     IDLE; re-enable resumes at next seq, counts preserved.
//   4 Drive 10 flits at i_data_valid (incl. 3 back-to-back) while transmitting -> o_rx_count=10,
//     o_data_ready stays 1, TX unaffected.
//   5 RX_CHECK_EN, ADDRESS=5: flits dest=5 src=2 seq 0,1,3 then dest=6 -> o_err_count=2;
//     undefined -> 0.
//   6 Assert rst mid-stall with valid high -> all outputs 0 asynchronously, seq/LFSR restart
//     from reset values after release.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared HNoC definitions: flit layout, LFSR taps, endpoint FSM states and flit helpers.
package noc_pkg;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned NUM_NODES = 2 ** ADDR_W;
  localparam int unsigned SEQ_W     = 24;

  localparam int unsigned DEST_MSB = 31;
  localparam int unsigned DEST_LSB = 28;
  localparam int unsigned SRC_MSB  = 27;
  localparam int unsigned SRC_LSB  = 24;
  localparam int unsigned SEQ_MSB  = 23;
  localparam int unsigned SEQ_LSB  = 0;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StSend,
    StDone
  } node_state_e;

  function automatic logic [31:0] make_flit(logic [3:0] dest, logic [3:0] src,
                                            logic [23:0] seq);
    return {dest, src, seq};
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/traffic_rx_checker.sv
// Per-source expected-sequence table; flags a received flit that is misaddressed or out of order.
module traffic_rx_checker #(
  parameter int unsigned ADDRESS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_flit,
  output logic        o_err
);
  import noc_pkg::*;

  localparam logic [3:0] OwnAddr = 4'(ADDRESS);

  logic [SEQ_W-1:0] exp_q [NUM_NODES];
  logic [SEQ_W-1:0] exp_d [NUM_NODES];
  logic [3:0]       dest;
  logic [3:0]       src;
  logic [SEQ_W-1:0] seq;

  assign dest = i_flit[DEST_MSB:DEST_LSB];
  assign src  = i_flit[SRC_MSB:SRC_LSB];
  assign seq  = i_flit[SEQ_MSB:SEQ_LSB];

  // Every flit resynchronises its source entry, so one gap costs exactly one error.
  always_comb begin
    exp_d = exp_q;
    if (i_valid) begin
      exp_d[src] = seq + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        exp_q[i] <= '0;
      end
    end else begin
      exp_q <= exp_d;
    end
  end

  assign o_err = i_valid && ((dest != OwnAddr) || (seq != exp_q[src]));

endmodule

// File: rtl/pe_traffic_node.sv
// HNoC processing-element endpoint: rate-limited random-destination injector plus flit sink.
// Define RX_CHECK_EN to add the received-flit address/sequence checker and error counter.
module pe_traffic_node #(
  parameter int unsigned ADDRESS    = 0,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned INJ_PERIOD = 8,
  parameter int unsigned NUM_PKTS   = 100,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic [31:0]       o_tx_count,
  output logic [31:0]       o_rx_count,
  output logic              o_done,
  output logic [15:0]       o_err_count
);
  import noc_pkg::*;

  localparam logic [ADDR_W-1:0] OwnAddr = ADDR_W'(ADDRESS);
  localparam logic [15:0] LfsrInit   = LFSR_SEED ^ 16'(ADDRESS);
  // Cycles spent in StGap are GapLoad + 1 = INJ_PERIOD - 1.
  localparam logic [31:0] GapLoad    = (INJ_PERIOD >= 2) ? 32'(INJ_PERIOD - 2) : 32'd0;
  localparam logic [31:0] LastIdx    = (NUM_PKTS == 0) ? 32'd0 : 32'(NUM_PKTS - 1);
  localparam bit          BackToBack = (INJ_PERIOD <= 1);
  localparam bit          Limited    = (NUM_PKTS != 0);

  node_state_e      state_q, state_d;
  logic [31:0]      gap_q, gap_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [31:0]      tx_q, tx_d;
  logic [31:0]      rx_q, rx_d;
  logic             ready_q, ready_d;
  logic [ADDR_W-1:0] dest;
  logic             rx_fire;

  assign rx_fire = i_data_valid && ready_q;
  assign dest    = (lfsr_q[ADDR_W-1:0] == OwnAddr) ? lfsr_q[ADDR_W-1:0] + ADDR_W'(1)
                                                   : lfsr_q[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    lfsr_d  = lfsr_q;
    seq_d   = seq_q;
    tx_d    = tx_q;
    unique case (state_q)
      StIdle: begin
        if (i_enable) begin
          gap_d   = GapLoad;
          state_d = BackToBack ? StSend : StGap;
        end
      end
      StGap: begin
        if (!i_enable) begin
          state_d = StIdle;
        end else if (gap_q == 32'd0) begin
          state_d = StSend;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      StSend: begin
        // i_enable is only honoured once the pending flit has been taken.
        if (i_data_ready) begin
          lfsr_d = lfsr_next(lfsr_q);
          seq_d  = seq_q + SEQ_W'(1);
          tx_d   = tx_q + 32'd1;
          gap_d  = GapLoad;
          if (Limited && (tx_q == LastIdx)) begin
            state_d = StDone;
          end else if (!i_enable) begin
            state_d = StIdle;
          end else begin
            state_d = BackToBack ? StSend : StGap;
          end
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rx_d    = rx_q + 32'(rx_fire);
    ready_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gap_q   <= '0;
      lfsr_q  <= LfsrInit;
      seq_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      lfsr_q  <= lfsr_d;
      seq_q   <= seq_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    o_data_valid = (state_q == StSend);
    o_data       = o_data_valid ? DATA_W'(make_flit(dest, OwnAddr, seq_q)) : '0;
  end

  assign o_data_ready = ready_q;
  assign o_tx_count   = tx_q;
  assign o_rx_count   = rx_q;
  assign o_done       = (state_q == StDone);

`ifdef RX_CHECK_EN
  logic        rx_err;
  logic [15:0] err_q, err_d;

  traffic_rx_checker #(
    .ADDRESS(ADDRESS)
  ) u_rx_checker (
    .clk    (clk),
    .rst    (rst),
    .i_valid(rx_fire),
    .i_flit (i_data[31:0]),
    .o_err  (rx_err)
  );

  always_comb begin
    err_d = err_q;
    if (rx_err && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err_count = err_q;
`else
  logic unused_rx_data;
  assign unused_rx_data = ^i_data;
  assign o_err_count    = '0;
`endif

endmodule

// File: tb/tb_pe_traffic_node.sv
// Bench for pe_traffic_node: three endpoints with different address/period/limit settings,
// directed protocol steps plus randomized ready/RX traffic against a scoreboard model.
module tb_pe_traffic_node;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en       [N];
  logic        rdy      [N];
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        ovalid   [N];
  logic        oready   [N];
  logic        done     [N];
  logic [31:0] odata    [N];
  logic [31:0] txc      [N];
  logic [31:0] rxc      [N];
  logic [15:0] errc     [N];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pe_traffic_node #(.ADDRESS(3), .INJ_PERIOD(4), .NUM_PKTS(5)) u_a (
    .clk(clk), .rst(rst), .i_enable(en[0]), .i_data(rx_data), .i_data_valid(rx_valid),
    .o_data_ready(oready[0]), .o_data(odata[0]), .o_data_valid(ovalid[0]),
    .i_data_ready(rdy[0]), .o_tx_count(txc[0]), .o_rx_count(rxc[0]), .o_done(done[0]),
    .o_err_count(errc[0]));

  pe_traffic_node #(.ADDRESS(5), .INJ_PERIOD(1), .NUM_PKTS(0)) u_b (
    .clk(clk), .rst(rst), .i_enable(en[1]), .i_data(rx_data), .i_data_valid(rx_valid),
    .o_data_ready(oready[1]), .o_data(odata[1]), .o_data_valid(ovalid[1]),
    .i_data_ready(rdy[1]), .o_tx_count(txc[1]), .o_rx_count(rxc[1]), .o_done(done[1]),
    .o_err_count(errc[1]));

  pe_traffic_node #(.ADDRESS(9), .INJ_PERIOD(3), .NUM_PKTS(0)) u_c (
    .clk(clk), .rst(rst), .i_enable(en[2]), .i_data(rx_data), .i_data_valid(rx_valid),
    .o_data_ready(oready[2]), .o_data(odata[2]), .o_data_valid(ovalid[2]),
    .i_data_ready(rdy[2]), .o_tx_count(txc[2]), .o_rx_count(rxc[2]), .o_done(done[2]),
    .o_err_count(errc[2]));

  function automatic logic [3:0] addr_of(int k);
    case (k)
      0:       return 4'd3;
      1:       return 4'd5;
      default: return 4'd9;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_valid(input int k, input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ovalid[k] && n < budget);
  endtask

  // Scoreboard: expected flit stream, counters and per-source RX sequence table.
  logic [15:0] m_lfsr [N];
  logic [23:0] m_seq  [N];
  logic [31:0] m_tx   [N];
  logic [31:0] m_rx   [N];
  logic [31:0] m_err  [N];
  logic [23:0] m_tbl  [N][16];
  logic        m_stall[N];
  logic [31:0] m_held [N];

  // Inputs change just after posedge, so the negedge view is what the next posedge samples.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        m_lfsr[k]  = 16'hACE1 ^ {12'h000, addr_of(k)};
        m_seq[k]   = '0;
        m_tx[k]    = '0;
        m_rx[k]    = '0;
        m_err[k]   = '0;
        m_stall[k] = 1'b0;
        m_held[k]  = '0;
        for (int s = 0; s < 16; s++) m_tbl[k][s] = '0;
      end else begin
        if (m_stall[k]) begin
          check("stall_valid_held", {31'b0, ovalid[k]}, 32'd1);
          check("stall_data_held", odata[k], m_held[k]);
        end
        if (ovalid[k] && rdy[k]) begin
          logic [3:0] d;
          d = m_lfsr[k][3:0];
          if (d == addr_of(k)) d = d + 4'd1;
          check("tx_flit", odata[k], {d, addr_of(k), m_seq[k]});
          check("tx_not_self", {31'b0, odata[k][31:28] == addr_of(k)}, 32'd0);
          m_lfsr[k] = (m_lfsr[k] >> 1) ^ (m_lfsr[k][0] ? 16'hB400 : 16'h0000);
          m_seq[k]  = m_seq[k] + 24'd1;
          m_tx[k]   = m_tx[k] + 32'd1;
        end
        m_stall[k] = ovalid[k] && !rdy[k];
        m_held[k]  = odata[k];
        if (rx_valid && oready[k]) begin
          m_rx[k] = m_rx[k] + 32'd1;
`ifdef RX_CHECK_EN
          begin
            logic [3:0] s;
            logic       bad;
            s   = rx_data[27:24];
            bad = (rx_data[31:28] != addr_of(k)) || (rx_data[23:0] != m_tbl[k][s]);
            m_tbl[k][s] = rx_data[23:0] + 24'd1;
            if (bad && m_err[k] < 32'hFFFF) m_err[k] = m_err[k] + 32'd1;
          end
`endif
        end
      end
    end
  end

  initial begin
    int n;
    logic [15:0] pat;
    logic [31:0] exp_err_b, exp_err_ac;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    for (int k = 0; k < N; k++) begin
      en[k]  = 1'b0;
      rdy[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      check("rst_valid", {31'b0, ovalid[k]}, 32'd0);
      check("rst_data", odata[k], 32'd0);
      check("rst_ready", {31'b0, oready[k]}, 32'd0);
      check("rst_tx", txc[k], 32'd0);
      check("rst_rx", rxc[k], 32'd0);
      check("rst_done", {31'b0, done[k]}, 32'd0);
      check("rst_err", {16'b0, errc[k]}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) check("ready_after_rst", {31'b0, oready[k]}, 32'd1);

    // Five flits at period 4 then sticky done.
    en[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(0, 20, n);
      check("a_gap_cycles", n, 32'd4);
      check("a_done_early", {31'b0, done[0]}, 32'd0);
    end
    @(posedge clk);
    #1;
    check("a_done", {31'b0, done[0]}, 32'd1);
    check("a_tx_count", txc[0], 32'd5);
    check("a_valid_off", {31'b0, ovalid[0]}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("a_done_sticky", {31'b0, done[0]}, 32'd1);
    check("a_no_more_valid", {31'b0, ovalid[0]}, 32'd0);
    check("a_tx_final", txc[0], 32'd5);

    // Period 1: back-to-back, stalled in cycles 2..6, then random ready.
    en[1] = 1'b1;
    wait_valid(1, 10, n);
    check("b_first_valid", n, 32'd1);
    for (int c = 0; c < 30; c++) begin
      if (c < 2) rdy[1] = 1'b1;
      else if (c < 7) rdy[1] = 1'b0;
      else rdy[1] = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("b_back_to_back", {31'b0, ovalid[1]}, 32'd1);
    end
    check("b_tx_count", txc[1], m_tx[1]);

    // Enable dropped in GAP, then in SEND while stalled.
    en[2] = 1'b1;
    wait_valid(2, 10, n);
    check("c_first_valid", n, 32'd3);
    @(posedge clk);
    #1;
    en[2] = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("c_gap_to_idle", {31'b0, ovalid[2]}, 32'd0);
    end
    en[2] = 1'b1;
    wait_valid(2, 10, n);
    check("c_resume_delay", n, 32'd3);
    rdy[2] = 1'b0;
    en[2]  = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("c_send_held", {31'b0, ovalid[2]}, 32'd1);
    end
    rdy[2] = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("c_send_to_idle", {31'b0, ovalid[2]}, 32'd0);
    end
    check("c_tx_preserved", txc[2], 32'd2);
    en[2] = 1'b1;
    wait_valid(2, 10, n);
    check("c_reenable_delay", n, 32'd3);
    @(posedge clk);
    #1;
    check("c_tx_count", txc[2], 32'd3);
    en[2] = 1'b0;

    // Ten RX flits (three back-to-back) while u_b keeps transmitting.
    pat = 16'b1110_1010_0110_1101;
    for (int i = 0; i < 16; i++) begin
      rx_valid = pat[15-i];
      rx_data  = $urandom;
      rdy[1]   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) check("rx_ready_high", {31'b0, oready[k]}, 32'd1);
    end
    rx_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("rx_count", rxc[k], 32'd10);
      check("rx_count_model", rxc[k], m_rx[k]);
      check("rx_err_model", {16'b0, errc[k]}, m_err[k]);
    end
    check("b_tx_during_rx", txc[1], m_tx[1]);

    // Asynchronous reset while u_b is stalled with valid high.
    rdy[1] = 1'b0;
    @(posedge clk);
    #1;
    check("f_stalled_valid", {31'b0, ovalid[1]}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      check("f_async_valid", {31'b0, ovalid[k]}, 32'd0);
      check("f_async_data", odata[k], 32'd0);
      check("f_async_tx", txc[k], 32'd0);
      check("f_async_rx", rxc[k], 32'd0);
      check("f_async_done", {31'b0, done[k]}, 32'd0);
      check("f_async_ready", {31'b0, oready[k]}, 32'd0);
    end
    for (int k = 0; k < N; k++) en[k] = 1'b0;
    rdy[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    en[1] = 1'b1;
    wait_valid(1, 10, n);
    check("f_restart_delay", n, 32'd1);
    check("f_restart_flit", odata[1], 32'h4500_0000);

    // RX checker: src 2 seq 0,1,3 to node 5, then a flit for node 6.
    rx_valid = 1'b1;
    rx_data  = 32'h5200_0000;
    @(posedge clk);
    #1;
    rx_data = 32'h5200_0001;
    @(posedge clk);
    #1;
    rx_data = 32'h5200_0003;
    @(posedge clk);
    #1;
    rx_data = 32'h6200_0004;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
`ifdef RX_CHECK_EN
    exp_err_b  = 32'd2;
    exp_err_ac = 32'd4;
`else
    exp_err_b  = 32'd0;
    exp_err_ac = 32'd0;
`endif
    check("e_err_b", {16'b0, errc[1]}, exp_err_b);
    check("e_err_a", {16'b0, errc[0]}, exp_err_ac);
    check("e_err_c", {16'b0, errc[2]}, exp_err_ac);
    for (int k = 0; k < N; k++) begin
      check("e_rx_count", rxc[k], 32'd4);
      check("e_err_model", {16'b0, errc[k]}, m_err[k]);
    end
    repeat (4) @(posedge clk);
    #1;
    check("end_b_tx", txc[1], m_tx[1]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
